mod3_arb: RTL
=============

MOD3_ARB -- requirements
Module: mod3_arb

Interface
REQ-001 SHALL have parameter W, default 8, meaning word width in bits (W >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester n presents a word.
REQ-005 SHALL have ports req0_data / req1_data  input  W  word to test, unsigned.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  word accepted this cycle when valid && ready.
REQ-007 SHALL have port res_valid  output  1  result available.
REQ-008 SHALL have port res_div  output  1  1 = accepted word divisible by 3.
REQ-009 SHALL have port res_id  output  1  requester index of the result.
REQ-010 SHALL have port res_ready  input  1  consumer takes the result when res_valid && res_ready.
REQ-011 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-012 SHALL share one serial divisibility engine between both requesters, one word in flight at a time.
REQ-013 SHALL implement the FSM IDLE -> START -> SHIFT -> FINISH -> WAIT -> RESULT -> IDLE.
REQ-014 IDLE: grant = round-robin winner among valid requesters; reqN_ready = (state==IDLE) && grant==N; on handshake latch data and id, go to START.
REQ-015 Round-robin: with both valid, the requester not granted last SHALL win; with one valid it SHALL win regardless of history.
REQ-016 The last-grant pointer SHALL update only on an accepted handshake.
REQ-017 START (1 cycle): drive engine start=1, in=0, finish=0.
REQ-018 SHALL stay in SHIFT for exactly W cycles, driving in = latched word bit W-1-k on SHIFT cycle k (MSB first), start=finish=0.
REQ-019 A W-bit bit counter SHALL wrap-check at W-1 and exit to FINISH; it SHALL NOT free-run past W-1.
REQ-020 FINISH (1 cycle): drive finish=1, in=0.
REQ-021 WAIT (1 cycle): register the engine out into res_div.
REQ-022 RESULT: res_valid=1; res_div and res_id SHALL stay stable until res_ready; on res_valid && res_ready go to IDLE.
REQ-023 Latency SHALL be: handshake at cycle t gives res_valid first high at cycle t+W+4.
REQ-024 Back-to-back: a new handshake SHALL be possible in the cycle after the result is taken, not in the same cycle.
REQ-025 reqN_valid dropping before acceptance SHALL be legal and SHALL cancel that request with no side effects.
REQ-026 res_div SHALL equal (word mod 3 == 0); the word 0 SHALL give res_div=1.

Reset
REQ-027 On rst high, asynchronously: state=IDLE; req0_ready, req1_ready, res_valid, res_div, res_id, busy and engine start/finish SHALL be 0; last grant = 1, so req0 wins first.
REQ-028 Reset mid-transaction SHALL discard the word in flight and any pending result; no result SHALL be emitted for it.
REQ-029 The engine has no reset; correctness SHALL rely on every transaction beginning with START.

Structure
REQ-030 Package mod3_pkg SHALL hold the FSM state encoding (6 states, 3 bits), the default W and the id width constant.
REQ-031 The single sub-module SHALL be mod3_engine: a serial MSB-first remainder-mod-3 unit with ports clk, in, start, finish, out.
REQ-032 mod3_engine SHALL use the start/in/finish/out protocol: start clears the remainder; each following cycle consumes in; finish registers out = (remainder==0).
REQ-033 The controller SHALL hold no arithmetic beyond the bit counter and the round-robin pointer.

Verification
REQ-034 After reset, req0 sends 8'd9 -> req0_ready at t, res_valid at t+12, res_div=1, res_id=0.
REQ-035 req1 sends 8'd10 -> res_div=0, res_id=1, latency 12 cycles.
REQ-036 Both valid continuously with req0=8'd3 and req1=8'd7 -> grants alternate 0,1,0,1; results alternate res_div 1,0.
REQ-037 res_ready held low for 5 cycles in RESULT -> res_valid, res_div and res_id stay stable, no new ready, then exactly one transfer.
REQ-038 rst pulsed during SHIFT for req0=8'd6 -> all outputs 0 immediately, no result emitted; next req1=8'd255 -> res_div=1.
REQ-039 Exhaustive sweep of 0..255 from alternating requesters -> res_div == (x%3==0) for every word; word 0 -> res_div=1.

Source files
------------

// File: rtl/mod3_pkg.sv
// Shared types and constants for the two-requester divisible-by-3 arbiter.
package mod3_pkg;

   localparam int unsigned W_DEFAULT = 8;
   localparam int unsigned ID_W      = 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_SHIFT  = 3'd2,
      S_FINISH = 3'd3,
      S_WAIT   = 3'd4,
      S_RESULT = 3'd5
   } state_e;

   // Remainder after appending one bit LSB-side: (2*rem + b) mod 3.
   function automatic logic [1:0] mod3_step(input logic [1:0] rem, input logic b);
      case ({rem, b})
         3'b000:  return 2'd0;
         3'b001:  return 2'd1;
         3'b010:  return 2'd2;
         3'b011:  return 2'd0;
         3'b100:  return 2'd1;
         3'b101:  return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/mod3_engine.sv
// Serial MSB-first remainder-mod-3 unit: start clears, each later cycle consumes in,
// finish registers out = (remainder == 0). No reset; every use begins with start.
module mod3_engine
   import mod3_pkg::*;
(
   input  logic clk,
   input  logic in,
   input  logic start,
   input  logic finish,
   output logic out
);

   logic [1:0] rem_q, rem_d;
   logic       out_q;

   always_comb begin
      rem_d = rem_q;
      if (start) begin
         rem_d = 2'd0;
      end else if (!finish) begin
         rem_d = mod3_step(rem_q, in);
      end
   end

   always_ff @(posedge clk) begin
      rem_q <= rem_d;
      if (finish) begin
         out_q <= (rem_q == 2'd0);
      end
   end

   assign out = out_q;

endmodule

// File: rtl/mod3_arb.sv
// Round-robin arbiter feeding one shared serial divisibility engine; one word in flight,
// result held until the consumer takes it.
module mod3_arb
   import mod3_pkg::*;
#(
   parameter int unsigned W = W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   input  logic [W-1:0] req0_data,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [W-1:0] req1_data,
   output logic         req1_ready,
   output logic         res_valid,
   output logic         res_div,
   output logic         res_id,
   input  logic         res_ready,
   output logic         busy
);

   localparam int unsigned CNT_W = W;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [W-1:0]      shift_q, shift_d;
   logic [ID_W-1:0]   last_q, last_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [ID_W-1:0]   grant_c;
   logic              grant_vld_c;
   logic              hs_c;
   logic              res_div_q, res_div_d;
   logic              res_valid_q;
   logic              busy_q;
   logic              eng_start_c, eng_in_c, eng_finish_c, eng_out;

   // Round-robin winner: the requester not granted last when both are valid.
   always_comb begin
      grant_vld_c = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant_c = ~last_q;
      end else if (req1_valid) begin
         grant_c = ID_W'(1);
      end else begin
         grant_c = ID_W'(0);
      end
   end

   assign req0_ready = !rst && (state_q == S_IDLE) && grant_vld_c && (grant_c == ID_W'(0));
   assign req1_ready = !rst && (state_q == S_IDLE) && grant_vld_c && (grant_c == ID_W'(1));
   assign hs_c       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      shift_d      = shift_q;
      last_d       = last_q;
      id_d         = id_q;
      res_div_d    = res_div_q;
      eng_start_c  = 1'b0;
      eng_in_c     = 1'b0;
      eng_finish_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (hs_c) begin
               state_d = S_START;
               last_d  = grant_c;
               id_d    = grant_c;
               shift_d = (grant_c == ID_W'(0)) ? req0_data : req1_data;
               cnt_d   = CNT_W'(0);
            end
         end
         S_START: begin
            eng_start_c = 1'b1;
            state_d     = S_SHIFT;
         end
         S_SHIFT: begin
            eng_in_c = shift_q[W-1];
            shift_d  = {shift_q[W-2:0], 1'b0};
            if (cnt_q == CNT_W'(W - 1)) begin
               state_d = S_FINISH;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_FINISH: begin
            eng_finish_c = 1'b1;
            state_d      = S_WAIT;
         end
         S_WAIT: begin
            res_div_d = eng_out;
            state_d   = S_RESULT;
         end
         S_RESULT: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= CNT_W'(0);
         shift_q     <= W'(0);
         last_q      <= ID_W'(1);
         id_q        <= ID_W'(0);
         res_div_q   <= 1'b0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         last_q      <= last_d;
         id_q        <= id_d;
         res_div_q   <= res_div_d;
         res_valid_q <= (state_d == S_RESULT);
         busy_q      <= (state_d != S_IDLE);
      end
   end

   mod3_engine u_engine (
      .clk    (clk),
      .in     (eng_in_c),
      .start  (eng_start_c),
      .finish (eng_finish_c),
      .out    (eng_out)
   );

   assign res_valid = res_valid_q;
   assign res_div   = res_div_q;
   assign res_id    = id_q;
   assign busy      = busy_q;

endmodule
